// File: rtl/pic_rw_if.sv
// Bus between the CPU-side strobes / data bus buffer and the PIC read/write control stage.
// The master drives the CPU strobes and write byte; the slave returns flags and register strobes.
interface pic_rw_if;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] din;
    logic       rd_flag;
    logic       wr_flag;
    logic       rd_a0;
    logic       icw1_stb;
    logic       icw2_stb;
    logic       icw3_stb;
    logic       icw4_stb;
    logic       ocw1_stb;
    logic       ocw2_stb;
    logic       ocw3_stb;
    logic [7:0] wr_data;
    logic       init_done;

    modport master (
        output cs_n, rd_n, wr_n, a0, din,
        input  rd_flag, wr_flag, rd_a0,
        input  icw1_stb, icw2_stb, icw3_stb, icw4_stb,
        input  ocw1_stb, ocw2_stb, ocw3_stb,
        input  wr_data, init_done
    );

    modport slave (
        input  cs_n, rd_n, wr_n, a0, din,
        output rd_flag, wr_flag, rd_a0,
        output icw1_stb, icw2_stb, icw3_stb, icw4_stb,
        output ocw1_stb, ocw2_stb, ocw3_stb,
        output wr_data, init_done
    );
endinterface

// File: rtl/pic_rw_ctrl.sv
// 8259A-style read/write control: synchronises CPU strobes, raises read/write flags,
// sequences ICW1..ICW4 and decodes OCW1..OCW3 into one-cycle register strobes.
module pic_rw_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    pic_rw_if.slave  bus
);

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    // Synchroniser chain, bit order {cs_n, rd_n, wr_n, a0}
    logic [3:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'b0000;
        end else begin
            r_sync[0] <= {bus.cs_n, bus.rd_n, bus.wr_n, bus.a0};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    logic [3:0] w_sync;
    logic       w_cs_s, w_rd_s, w_wr_s, w_a0_s;
    logic       w_rd_act, w_wr_act, w_ovl, w_wr_fall;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_cs_s    = w_sync[3];
    assign w_rd_s    = w_sync[2];
    assign w_wr_s    = w_sync[1];
    assign w_a0_s    = w_sync[0];
    assign w_rd_act  = ~w_cs_s & ~w_rd_s &  w_wr_s;
    assign w_wr_act  = ~w_cs_s & ~w_wr_s &  w_rd_s;
    assign w_ovl     = ~w_cs_s & ~w_rd_s & ~w_wr_s;

    logic       r_rd_flag, r_wr_flag, r_rd_a0;
    logic       r_wr_a0, r_wr_armed, r_commit;
    logic [7:0] r_wr_byte;

    assign w_wr_fall = r_wr_flag & ~w_wr_act;

    // A write only commits if wr was seen idle beforehand (so a write already in progress
    // when reset lifts is discarded) and no rd/wr overlap happened during it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_flag  <= 1'b0;
            r_wr_flag  <= 1'b0;
            r_rd_a0    <= 1'b0;
            r_wr_a0    <= 1'b0;
            r_wr_byte  <= 8'h00;
            r_wr_armed <= 1'b0;
            r_commit   <= 1'b0;
        end else begin
            r_rd_flag <= w_rd_act;
            r_wr_flag <= w_wr_act;
            if (w_rd_act) r_rd_a0 <= w_a0_s;
            if (w_wr_act) begin
                r_wr_byte <= bus.din;
                r_wr_a0   <= w_a0_s;
            end
            if (w_wr_s)     r_wr_armed <= 1'b1;
            else if (w_ovl) r_wr_armed <= 1'b0;
            r_commit <= w_wr_fall & r_wr_armed & ~w_ovl;
        end
    end

    state_t     r_state, w_state_next;
    logic       r_sngl, r_ic4, r_init_done;
    logic       w_sngl_next, w_ic4_next, w_init_next;
    logic [6:0] r_stb, w_stb_next;   // {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}
    logic [7:0] r_wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= UNINIT;
            r_sngl      <= 1'b0;
            r_ic4       <= 1'b0;
            r_init_done <= 1'b0;
            r_stb       <= 7'b0;
            r_wr_data   <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_sngl      <= w_sngl_next;
            r_ic4       <= w_ic4_next;
            r_init_done <= w_init_next;
            r_stb       <= w_stb_next;
            if (r_commit) r_wr_data <= r_wr_byte;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sngl_next  = r_sngl;
        w_ic4_next   = r_ic4;
        w_init_next  = r_init_done;
        w_stb_next   = 7'b0;
        if (r_commit) begin
            if (!r_wr_a0 && r_wr_byte[4]) begin
                // ICW1 restarts initialisation from any state
                w_stb_next[0] = 1'b1;
                w_sngl_next   = r_wr_byte[1];
                w_ic4_next    = r_wr_byte[0];
                w_init_next   = 1'b0;
                w_state_next  = WAIT_ICW2;
            end else begin
                case (r_state)
                    WAIT_ICW2: if (r_wr_a0) begin
                        w_stb_next[1] = 1'b1;
                        if (!r_sngl)    w_state_next = WAIT_ICW3;
                        else if (r_ic4) w_state_next = WAIT_ICW4;
                        else begin
                            w_state_next = READY;
                            w_init_next  = 1'b1;
                        end
                    end
                    WAIT_ICW3: if (r_wr_a0) begin
                        w_stb_next[2] = 1'b1;
                        if (r_ic4) w_state_next = WAIT_ICW4;
                        else begin
                            w_state_next = READY;
                            w_init_next  = 1'b1;
                        end
                    end
                    WAIT_ICW4: if (r_wr_a0) begin
                        w_stb_next[3] = 1'b1;
                        w_state_next  = READY;
                        w_init_next   = 1'b1;
                    end
                    READY: begin
                        if (r_wr_a0)           w_stb_next[4] = 1'b1;
                        else if (!r_wr_byte[3]) w_stb_next[5] = 1'b1;
                        else                    w_stb_next[6] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_flag   = r_rd_flag;
    assign bus.wr_flag   = r_wr_flag;
    assign bus.rd_a0     = r_rd_a0;
    assign bus.icw1_stb  = r_stb[0];
    assign bus.icw2_stb  = r_stb[1];
    assign bus.icw3_stb  = r_stb[2];
    assign bus.icw4_stb  = r_stb[3];
    assign bus.ocw1_stb  = r_stb[4];
    assign bus.ocw2_stb  = r_stb[5];
    assign bus.ocw3_stb  = r_stb[6];
    assign bus.wr_data   = r_wr_data;
    assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_pic_rw_ctrl.sv
// Bench for pic_rw_ctrl: directed CPU cycles, expected strobes queued at issue time and
// popped by an independent monitor whenever any register strobe appears.
module tb_pic_rw_ctrl;

    localparam int K_ICW1 = 0, K_ICW2 = 1, K_ICW3 = 2, K_ICW4 = 3;
    localparam int K_OCW1 = 4, K_OCW2 = 5, K_OCW3 = 6, K_NONE = -1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       init;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t q[$];

    pic_rw_if bus ();

    pic_rw_ctrl #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] stb;
    assign stb = {bus.ocw3_stb, bus.ocw2_stb, bus.ocw1_stb,
                  bus.icw4_stb, bus.icw3_stb, bus.icw2_stb, bus.icw1_stb};

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && stb != 7'b0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got stb=%b wr_data=%h, required no strobe", stb, bus.wr_data);
            end else begin
                exp_t e;
                logic [6:0] want;
                e    = q.pop_front();
                want = 7'b1 << e.kind;
                if (stb !== want || bus.wr_data !== e.data || bus.init_done !== e.init) begin
                    errors++;
                    $display("FAIL strobe got stb=%b data=%h init=%b, required stb=%b data=%h init=%b",
                             stb, bus.wr_data, bus.init_done, want, e.data, e.init);
                end else begin
                    $display("strobe stb=%b data=%h init=%b ok", stb, bus.wr_data, bus.init_done);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_flag"},   {7'b0, bus.rd_flag},   8'h00);
        chk({tag, "_wr_flag"},   {7'b0, bus.wr_flag},   8'h00);
        chk({tag, "_rd_a0"},     {7'b0, bus.rd_a0},     8'h00);
        chk({tag, "_stb"},       {1'b0, stb},           8'h00);
        chk({tag, "_wr_data"},   bus.wr_data,           8'h00);
        chk({tag, "_init_done"}, {7'b0, bus.init_done}, 8'h00);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL strobe_timeout got %0d pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d, input int kind, input logic init);
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.a0   = a;
        bus.din  = d;
        bus.wr_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("wr_flag_during_write", {7'b0, bus.wr_flag}, 8'h01);
        if (kind != K_NONE) q.push_back('{kind, d, init});
        $display("write a0=%0d din=%h expect kind=%0d", a, d, kind);
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.a0   = 1'b0;
        bus.din  = 8'h00;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // ICW1 single + IC4, ICW2, ICW4 (no ICW3)
        bus_write(1'b0, 8'h13, K_ICW1, 1'b0);
        bus_write(1'b1, 8'h20, K_ICW2, 1'b0);
        bus_write(1'b1, 8'h01, K_ICW4, 1'b1);
        chk("init_done_after_icw4", {7'b0, bus.init_done}, 8'h01);
        chk("wr_data_after_icw4", bus.wr_data, 8'h01);

        // Reset in the middle of a write: outputs clear at once, write is discarded
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.a0   = 1'b1;
        bus.din  = 8'h55;
        bus.wr_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("wr_flag_before_reset", {7'b0, bus.wr_flag}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midwrite_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("wr_data_after_abort", bus.wr_data, 8'h00);

        // UNINIT ignores non-ICW1 writes
        bus_write(1'b1, 8'hFE, K_NONE, 1'b0);
        chk("init_done_uninit", {7'b0, bus.init_done}, 8'h00);

        // Cascade + IC4: all four ICWs; an a0=0 non-ICW1 write in WAIT_ICW2 is ignored
        bus_write(1'b0, 8'h11, K_ICW1, 1'b0);
        bus_write(1'b0, 8'h08, K_NONE, 1'b0);
        bus_write(1'b1, 8'h08, K_ICW2, 1'b0);
        bus_write(1'b1, 8'h04, K_ICW3, 1'b0);
        bus_write(1'b1, 8'h03, K_ICW4, 1'b1);

        // READY decode
        bus_write(1'b1, 8'hFE, K_OCW1, 1'b1);
        bus_write(1'b0, 8'h20, K_OCW2, 1'b1);
        bus_write(1'b0, 8'h0B, K_OCW3, 1'b1);
        chk("wr_data_after_ocw3", bus.wr_data, 8'h0B);

        // ICW1 restart before ICW2; second ICW1 has ic4=0, single -> READY after ICW2
        bus_write(1'b0, 8'h13, K_ICW1, 1'b0);
        bus_write(1'b0, 8'h12, K_ICW1, 1'b0);
        bus_write(1'b1, 8'h40, K_ICW2, 1'b1);
        bus_write(1'b1, 8'h00, K_OCW1, 1'b1);

        // rd_n and wr_n overlapping: no flags, no strobe
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.a0   = 1'b1;
        bus.rd_n = 1'b0;
        bus.wr_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("ovl_rd_flag", {7'b0, bus.rd_flag}, 8'h00);
            chk("ovl_wr_flag", {7'b0, bus.wr_flag}, 8'h00);
        end
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        repeat (10) @(negedge clk);

        // Write aborted by rd_n falling during it: no commit
        bus.cs_n = 1'b0;
        bus.a0   = 1'b0;
        bus.din  = 8'h0B;
        bus.wr_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.rd_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("wr_data_after_rd_abort", bus.wr_data, 8'h00);

        // Read a0=1: flag latency SYNC_STAGES+1, rd_a0 captured
        chk("rd_a0_before_read", {7'b0, bus.rd_a0}, 8'h00);
        bus.cs_n = 1'b0;
        bus.a0   = 1'b1;
        bus.rd_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rd_flag_latency_early", {7'b0, bus.rd_flag}, 8'h00);
        @(negedge clk);
        chk("rd_flag_latency", {7'b0, bus.rd_flag}, 8'h01);
        chk("rd_a0_read", {7'b0, bus.rd_a0}, 8'h01);
        $display("read a0=1 rd_flag=%b rd_a0=%b", bus.rd_flag, bus.rd_a0);
        bus.rd_n = 1'b1;
        bus.cs_n = 1'b1;
        bus.a0   = 1'b0;
        repeat (4) @(negedge clk);
        chk("rd_flag_after_read", {7'b0, bus.rd_flag}, 8'h00);
        chk("rd_a0_held", {7'b0, bus.rd_a0}, 8'h01);
        chk("init_done_after_read", {7'b0, bus.init_done}, 8'h01);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
